// File: rtl/ddr3_init_seq_if.sv
// DDR3 command pins and the init/refresh handshake between ddr3_init_seq and its neighbours.
interface ddr3_init_seq_if;
  logic        ddr3_rstn;
  logic        ddr3_cke;
  logic        ddr3_csn;
  logic        ddr3_rasn;
  logic        ddr3_casn;
  logic        ddr3_wen;
  logic [2:0]  ddr3_ba;
  logic [12:0] ddr3_a;
  logic        ddr3_odt;
  logic        init_done;
  logic        ref_req;
  logic        ref_ack;

  modport master (
    output ddr3_rstn, ddr3_cke, ddr3_csn, ddr3_rasn, ddr3_casn, ddr3_wen,
           ddr3_ba, ddr3_a, ddr3_odt, init_done, ref_req,
    input  ref_ack
  );

  modport slave (
    input  ddr3_rstn, ddr3_cke, ddr3_csn, ddr3_rasn, ddr3_casn, ddr3_wen,
           ddr3_ba, ddr3_a, ddr3_odt, init_done, ref_req,
    output ref_ack
  );
endinterface

// File: rtl/ddr3_init_seq.sv
// DDR3 power-up/init sequencer: reset hold, CKE wait, MRS2/3/1/0, ZQCL, then init_done.
// Optional periodic refresh with ref_req/ref_ack handshake when DDR3_AUTO_REFRESH_EN is defined.
module ddr3_init_seq #(
  parameter int unsigned T_RST    = 10000,
  parameter int unsigned T_CKE    = 25000,
  parameter int unsigned T_XPR    = 9,
  parameter int unsigned T_MRD    = 4,
  parameter int unsigned T_MOD    = 12,
  parameter int unsigned T_ZQINIT = 512,
  parameter int unsigned T_REFI   = 390,
  parameter int unsigned T_RFC    = 8,
  parameter logic [15:0] MR0      = 16'h0520,
  parameter logic [15:0] MR1      = 16'h0004,
  parameter logic [15:0] MR2      = 16'h0008,
  parameter logic [15:0] MR3      = 16'h0000
) (
  input  logic            osc,
  input  logic            perstn,
  ddr3_init_seq_if.master ddr
);

  typedef enum logic [3:0] {
    S_RST_HOLD,
    S_CKE_WAIT,
    S_TXPR,
    S_MRS2,
    S_MRS3,
    S_MRS1,
    S_MRS0,
    S_ZQCL,
    S_DONE,
    S_REF_REQ,
    S_REF
  } state_e;

  typedef struct packed {
    logic        rstn;
    logic        cke;
    logic        csn;
    logic        rasn;
    logic        casn;
    logic        wen;
    logic [2:0]  ba;
    logic [12:0] a;
    logic        init_done;
    logic        ref_req;
  } pins_t;

  // {csn, rasn, casn, wen}
  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam logic [3:0] CMD_ZQCL  = 4'b0110;
  localparam logic [3:0] CMD_REF   = 4'b0001;

  localparam pins_t PINS_RESET = '{
    rstn: 1'b0, cke: 1'b0, csn: 1'b1, rasn: 1'b1, casn: 1'b1, wen: 1'b1,
    ba: 3'd0, a: 13'd0, init_done: 1'b0, ref_req: 1'b0
  };

  // Each counter load is wait-1 so a state lasts exactly its wait and leaves on zero.
  localparam logic [19:0] LD_RST    = 20'(T_RST - 1);
  localparam logic [19:0] LD_CKE    = 20'(T_CKE - 1);
  localparam logic [19:0] LD_XPR    = 20'(T_XPR - 1);
  localparam logic [19:0] LD_MRD    = 20'(T_MRD - 1);
  localparam logic [19:0] LD_MOD    = 20'(T_MOD - 1);
  localparam logic [19:0] LD_ZQINIT = 20'(T_ZQINIT - 1);
  localparam logic [19:0] LD_REFI   = 20'(T_REFI - 1);
  localparam logic [19:0] LD_RFC    = 20'(T_RFC - 1);

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  pins_t       pins_q, pins_d;
  logic        cnt_zero;

  function automatic logic [19:0] load_for(input state_e s);
    case (s)
      S_RST_HOLD:             load_for = LD_RST;
      S_CKE_WAIT:             load_for = LD_CKE;
      S_TXPR:                 load_for = LD_XPR;
      S_MRS2, S_MRS3, S_MRS1: load_for = LD_MRD;
      S_MRS0:                 load_for = LD_MOD;
      // ZQCL cycle plus its NOP tail together span T_ZQINIT.
      S_ZQCL:                 load_for = LD_ZQINIT;
      S_DONE:                 load_for = LD_REFI;
      S_REF:                  load_for = LD_RFC;
      default:                load_for = 20'd0;
    endcase
  endfunction

  assign cnt_zero = (cnt_q == 20'd0);

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? 20'd0 : cnt_q - 20'd1;
    case (state_q)
      S_RST_HOLD: if (cnt_zero) state_d = S_CKE_WAIT;
      S_CKE_WAIT: if (cnt_zero) state_d = S_TXPR;
      S_TXPR:     if (cnt_zero) state_d = S_MRS2;
      S_MRS2:     if (cnt_zero) state_d = S_MRS3;
      S_MRS3:     if (cnt_zero) state_d = S_MRS1;
      S_MRS1:     if (cnt_zero) state_d = S_MRS0;
      S_MRS0:     if (cnt_zero) state_d = S_ZQCL;
      S_ZQCL:     if (cnt_zero) state_d = S_DONE;
      S_DONE: begin
`ifdef DDR3_AUTO_REFRESH_EN
        if (cnt_zero) state_d = S_REF_REQ;
`endif
      end
      S_REF_REQ:  if (ddr.ref_ack) state_d = S_REF;
      S_REF:      if (cnt_zero) state_d = S_DONE;
      default:    state_d = S_RST_HOLD;
    endcase
    if (state_d != state_q) cnt_d = load_for(state_d);
  end

  // Pin values are derived from the next state so they register alongside it;
  // a command is driven only on the first cycle of its state.
  always_comb begin
    pins_d           = PINS_RESET;
    pins_d.rstn      = (state_d != S_RST_HOLD);
    pins_d.cke       = !(state_d inside {S_RST_HOLD, S_CKE_WAIT});
    {pins_d.csn, pins_d.rasn, pins_d.casn, pins_d.wen} = pins_d.cke ? CMD_NOP : CMD_DESEL;
    pins_d.init_done = (state_d inside {S_DONE, S_REF_REQ, S_REF});
    pins_d.ref_req   = (state_d == S_REF_REQ);
    if (state_d != state_q) begin
      case (state_d)
        S_MRS2: begin
          {pins_d.csn, pins_d.rasn, pins_d.casn, pins_d.wen} = CMD_MRS;
          pins_d.ba = 3'd2;
          pins_d.a  = MR2[12:0];
        end
        S_MRS3: begin
          {pins_d.csn, pins_d.rasn, pins_d.casn, pins_d.wen} = CMD_MRS;
          pins_d.ba = 3'd3;
          pins_d.a  = MR3[12:0];
        end
        S_MRS1: begin
          {pins_d.csn, pins_d.rasn, pins_d.casn, pins_d.wen} = CMD_MRS;
          pins_d.ba = 3'd1;
          pins_d.a  = MR1[12:0];
        end
        S_MRS0: begin
          {pins_d.csn, pins_d.rasn, pins_d.casn, pins_d.wen} = CMD_MRS;
          pins_d.ba = 3'd0;
          pins_d.a  = MR0[12:0];
        end
        S_ZQCL: begin
          {pins_d.csn, pins_d.rasn, pins_d.casn, pins_d.wen} = CMD_ZQCL;
          pins_d.a = 13'h0400;
        end
        S_REF: {pins_d.csn, pins_d.rasn, pins_d.casn, pins_d.wen} = CMD_REF;
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses <= so every register samples the pre-edge values.
  always_ff @(posedge osc or negedge perstn) begin
    if (!perstn) begin
      state_q <= S_RST_HOLD;
      cnt_q   <= LD_RST;
      pins_q  <= PINS_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pins_q  <= pins_d;
    end
  end

  assign ddr.ddr3_rstn = pins_q.rstn;
  assign ddr.ddr3_cke  = pins_q.cke;
  assign ddr.ddr3_csn  = pins_q.csn;
  assign ddr.ddr3_rasn = pins_q.rasn;
  assign ddr.ddr3_casn = pins_q.casn;
  assign ddr.ddr3_wen  = pins_q.wen;
  assign ddr.ddr3_ba   = pins_q.ba;
  assign ddr.ddr3_a    = pins_q.a;
  assign ddr.ddr3_odt  = 1'b0;
  assign ddr.init_done = pins_q.init_done;
  assign ddr.ref_req   = pins_q.ref_req;

endmodule
